// File: rtl/lsfr_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsfr_readout_pkg
//  Description : Shared types, constants and LFSR helper for the pixel-column
//                readout controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsfr_readout_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        EXPOSE = 3'd2,
        SETTLE = 3'd3,
        SHIFT  = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    localparam int RST_CYC   = 2;
    localparam int WBITS_DEF = 15;

    // One counting step of the in-pixel 15-bit LFSR (taps 15 and 14).
    function automatic logic [14:0] lfsr15_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsfr_readout_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsfr_readout_ctrl_if
//  Description : Valid/ready stream carrying one pixel word and its index.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsfr_readout_ctrl_if #(
    parameter int NPIX  = 16,
    parameter int WBITS = 15
) ();
    localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic [WBITS-1:0] out_data;
    logic [PIXW-1:0]  out_pix;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_pix, output out_valid, input out_ready);
    modport slave  (input out_data, input out_pix, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/lsfr_deser.sv
`default_nettype none
// ============================================================================
//  Module      : lsfr_deser
//  Description : Deserialises the pixel chain bit stream into per-pixel words
//                and holds them on a valid/ready output register. A completed
//                word that cannot be handed over waits in the shift register
//                and raises stall so no further bits are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsfr_deser #(
    parameter int NPIX  = 16,
    parameter int WBITS = 15
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic sample,
    input  wire logic ser_bit,
    output logic      stall,
    output logic      chain_done,
    output logic      drain_ok,
    lsfr_readout_ctrl_if.master ostream
);
    localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BCW  = (WBITS > 1) ? $clog2(WBITS) : 1;

    logic [WBITS-1:0] sreg;
    logic [BCW-1:0]   bcnt;
    logic [PIXW-1:0]  pcnt;
    logic             pending;
    logic [WBITS-1:0] data_q;
    logic [PIXW-1:0]  pix_q;
    logic             valid_q;

    logic             bit_last;
    logic             pix_last;
    logic             word_done;
    logic             out_free;
    logic [WBITS-1:0] word_next;

    assign bit_last   = (bcnt == BCW'(WBITS - 1));
    assign pix_last   = (pcnt == PIXW'(NPIX - 1));
    assign word_done  = sample && bit_last;
    assign out_free   = !valid_q || ostream.out_ready;
    assign word_next  = {sreg[WBITS-2:0], ser_bit};

    assign stall      = pending;
    assign chain_done = word_done && pix_last;
    assign drain_ok   = !pending && out_free;

    assign ostream.out_data  = data_q;
    assign ostream.out_pix   = pix_q;
    assign ostream.out_valid = valid_q;

    // Shift in sampled bits and move finished words into the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bcnt    <= '0;
            pcnt    <= '0;
            pending <= 1'b0;
            data_q  <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            sreg    <= '0;
            bcnt    <= '0;
            pcnt    <= '0;
            pending <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (valid_q && ostream.out_ready) begin
                valid_q <= 1'b0;
            end
            if (sample) begin
                sreg <= word_next;
                bcnt <= bit_last ? '0 : bcnt + 1'b1;
            end
            // A handshake in the same cycle frees the register for the new word.
            if (word_done && out_free) begin
                data_q  <= word_next;
                pix_q   <= pcnt;
                valid_q <= 1'b1;
                pcnt    <= pcnt + 1'b1;
            end else if (word_done) begin
                pending <= 1'b1;
            end else if (pending && out_free) begin
                data_q  <= sreg;
                pix_q   <= pcnt;
                valid_q <= 1'b1;
                pcnt    <= pcnt + 1'b1;
                pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsfr_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsfr_readout_ctrl
//  Description : Frame sequencer for a daisy-chained column of LFSR counting
//                pixels: counter reset, exposure window, settle, then a
//                two-phase read-clock shift-out deserialised into words.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsfr_readout_ctrl
    import lsfr_readout_pkg::*;
#(
    parameter int NPIX       = 16,
    parameter int WBITS      = 15,
    parameter int EXP_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [EXP_W-1:0] exp_len,
    output logic                  busy,
    output logic                  pix_shutter,
    output logic                  pix_clk_read,
    output logic                  pix_reset,
    output logic                  pix_ser_in,
    input  wire logic             pix_ser_out,
    lsfr_readout_ctrl_if.master   ostream
);
    state_t           state;
    logic [EXP_W-1:0] cnt;
    logic [EXP_W-1:0] exp_q;
    logic             last_slot;

    logic             abort_eff;
    logic             start_acc;
    logic             sample;
    logic             clear;
    logic             stall;
    logic             chain_done;
    logic             drain_ok;

    assign abort_eff = abort && (state != IDLE);
    assign start_acc = (state == IDLE) && start && !abort;
    assign clear     = abort_eff || start_acc;
    // Phase A of a bit slot is a SHIFT cycle with the read clock low.
    assign sample    = (state == SHIFT) && !pix_clk_read && !stall;

    lsfr_deser #(
        .NPIX  (NPIX),
        .WBITS (WBITS)
    ) u_deser (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .sample     (sample),
        .ser_bit    (pix_ser_out),
        .stall      (stall),
        .chain_done (chain_done),
        .drain_ok   (drain_ok),
        .ostream    (ostream)
    );

    // Frame state machine; every pixel-side output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            pix_shutter  <= 1'b1;
            pix_clk_read <= 1'b0;
            pix_reset    <= 1'b0;
            pix_ser_in   <= 1'b1;
            cnt          <= '0;
            exp_q        <= '0;
            last_slot    <= 1'b0;
        end else if (abort_eff) begin
            state        <= IDLE;
            busy         <= 1'b0;
            pix_shutter  <= 1'b1;
            pix_clk_read <= 1'b0;
            pix_reset    <= 1'b0;
            cnt          <= '0;
            last_slot    <= 1'b0;
        end else begin
            // Chain refills with the all-ones reset pattern.
            pix_ser_in <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        exp_q     <= (exp_len == '0) ? EXP_W'(1) : exp_len;
                        state     <= RST;
                        busy      <= 1'b1;
                        pix_reset <= 1'b1;
                        cnt       <= EXP_W'(RST_CYC);
                        last_slot <= 1'b0;
                    end
                end
                RST: begin
                    if (cnt <= EXP_W'(1)) begin
                        state       <= EXPOSE;
                        pix_reset   <= 1'b0;
                        pix_shutter <= 1'b0;
                        cnt         <= exp_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXPOSE: begin
                    if (cnt <= EXP_W'(1)) begin
                        state       <= SETTLE;
                        pix_shutter <= 1'b1;
                        cnt         <= EXP_W'(SETTLE_CYC);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt <= EXP_W'(1)) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (pix_clk_read) begin
                        pix_clk_read <= 1'b0;
                        if (last_slot) begin
                            state <= DRAIN;
                        end
                    end else if (!stall) begin
                        pix_clk_read <= 1'b1;
                        if (chain_done) begin
                            last_slot <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsfr_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsfr_readout_ctrl
//  Description : Directed bench with a behavioural 4-pixel LFSR chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsfr_readout_ctrl;
    import lsfr_readout_pkg::*;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] exp_len;
    logic        busy, pix_shutter, pix_clk_read, pix_reset, pix_ser_in;
    logic        pix_ser_out;
    logic        out_ready;

    lsfr_readout_ctrl_if #(.NPIX(NP), .WBITS(15)) stream ();

    wire         out_valid = stream.out_valid;
    wire [14:0]  out_data  = stream.out_data;
    wire [1:0]   out_pix   = stream.out_pix;
    assign stream.out_ready = out_ready;

    lsfr_readout_ctrl #(.NPIX(NP), .WBITS(15), .EXP_W(16), .SETTLE_CYC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .exp_len      (exp_len),
        .busy         (busy),
        .pix_shutter  (pix_shutter),
        .pix_clk_read (pix_clk_read),
        .pix_reset    (pix_reset),
        .pix_ser_in   (pix_ser_in),
        .pix_ser_out  (pix_ser_out),
        .ostream      (stream)
    );

    always #5 clk = ~clk;

    // Pixel chain model: index 0 drives pix_ser_out, index NP-1 takes pix_ser_in.
    logic [14:0] chain [NP];
    int          npulse [NP];
    int          m_low;
    logic        m_prev;
    assign pix_ser_out = chain[0][14];

    always @(posedge clk) begin
        if (pix_reset) begin
            for (int i = 0; i < NP; i++) chain[i] <= 15'h7FFF;
            m_low <= 0;
        end else if (!pix_shutter) begin
            for (int i = 0; i < NP; i++)
                if (m_low < npulse[i]) chain[i] <= lfsr15_next(chain[i]);
            m_low <= m_low + 1;
        end else if (pix_clk_read && !m_prev) begin
            for (int i = 0; i < NP - 1; i++) chain[i] <= {chain[i][13:0], chain[i+1][14]};
            chain[NP-1] <= {chain[NP-1][13:0], pix_ser_in};
        end
        m_prev <= pix_clk_read;
    end

    // Frame monitor: cycle counts and accepted words, cleared on an accepted start.
    int          busy_cyc, rst_cyc, low_cyc, gap_cyc, rises;
    logic        mon_prev = 1'b0;
    logic [14:0] wd_q [$];
    logic [1:0]  wp_q [$];

    always @(posedge clk) begin
        if (start && !busy && !reset) begin
            busy_cyc = 0; rst_cyc = 0; low_cyc = 0; gap_cyc = 0; rises = 0;
            wd_q.delete(); wp_q.delete();
        end else begin
            if (busy) busy_cyc++;
            if (pix_reset) rst_cyc++;
            if (!pix_shutter) low_cyc++;
            if (busy && pix_shutter && !pix_reset && !pix_clk_read && low_cyc > 0 && rises == 0)
                gap_cyc++;
            if (pix_clk_read && !mon_prev) rises++;
            if (out_valid && out_ready) begin
                wd_q.push_back(out_data);
                wp_q.push_back(out_pix);
            end
        end
        mon_prev = pix_clk_read;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] len);
        exp_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_frame_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [14:0] e0, input logic [14:0] e1,
                               input logic [14:0] e2, input logic [14:0] e3, input int exp_busy);
        logic [14:0] ev [NP];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        check({tag, "_nwords"}, wd_q.size(), NP);
        for (int i = 0; i < NP; i++) begin
            if (i < wd_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), {17'd0, wd_q[i]}, {17'd0, ev[i]});
                check($sformatf("%s_pix%0d", tag, i), {30'd0, wp_q[i]}, i);
            end
        end
        if (exp_busy > 0) check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    endtask

    initial begin
        int k;
        int r0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; exp_len = '0; out_ready = 1'b1;
        for (int i = 0; i < NP; i++) npulse[i] = 0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy",    {31'd0, busy},         0);
        check("rst_shutter", {31'd0, pix_shutter},  1);
        check("rst_clkread", {31'd0, pix_clk_read}, 0);
        check("rst_pixrst",  {31'd0, pix_reset},    0);
        check("rst_serin",   {31'd0, pix_ser_in},   1);
        check("rst_valid",   {31'd0, out_valid},    0);
        check("rst_data",    {17'd0, out_data},     0);
        check("rst_pix",     {30'd0, out_pix},      0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame: exp_len=10, 3 pulses per pixel -> 0x7FF8
        for (int i = 0; i < NP; i++) npulse[i] = 3;
        start_frame(16'd10);
        check("basic_busy_next", {31'd0, busy},      1);
        check("basic_pixrst_on", {31'd0, pix_reset}, 1);
        wait_idle("basic", 400);
        check("basic_rst_cyc", rst_cyc, 2);
        check("basic_low_cyc", low_cyc, 10);
        check("basic_settle",  gap_cyc, 5);
        check("basic_rises",   rises,   60);
        check_frame("basic", 15'h7FF8, 15'h7FF8, 15'h7FF8, 15'h7FF8, 137);

        // Zero pulses
        for (int i = 0; i < NP; i++) npulse[i] = 0;
        start_frame(16'd5);
        wait_idle("zero", 400);
        check("zero_low_cyc", low_cyc, 5);
        check_frame("zero", 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 132);

        // Backpressure: distinct pulse counts per pixel, ready low 50 cycles after first word
        for (int i = 0; i < NP; i++) npulse[i] = i + 1;
        start_frame(16'd6);
        k = 0;
        while (out_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        check("bp_first_valid", {31'd0, out_valid}, 1);
        out_ready = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i >= 35 && i <= 44) check($sformatf("bp_stall_clk%0d", i), {31'd0, pix_clk_read}, 0);
            if (i == 45) begin
                check("bp_hold_valid", {31'd0, out_valid}, 1);
                check("bp_hold_data",  {17'd0, out_data},  32'h7FFE);
                check("bp_hold_pix",   {30'd0, out_pix},   0);
            end
        end
        out_ready = 1'b1;
        wait_idle("bp", 400);
        check_frame("bp", 15'h7FFE, 15'h7FFC, 15'h7FF8, 15'h7FF0, 0);

        // Abort during EXPOSE, then a clean frame
        for (int i = 0; i < NP; i++) npulse[i] = 3;
        start_frame(16'd10);
        k = 0;
        while (pix_shutter !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("abx_in_expose", {31'd0, pix_shutter}, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abx_busy",    {31'd0, busy},         0);
        check("abx_shutter", {31'd0, pix_shutter},  1);
        check("abx_valid",   {31'd0, out_valid},    0);
        check("abx_pixrst",  {31'd0, pix_reset},    0);
        @(negedge clk);
        start_frame(16'd10);
        wait_idle("abx_re", 400);
        check_frame("abx_re", 15'h7FF8, 15'h7FF8, 15'h7FF8, 15'h7FF8, 137);

        // Abort mid-SHIFT with a word held valid, then a clean frame
        out_ready = 1'b0;
        start_frame(16'd10);
        k = 0;
        while (out_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        k = 0;
        while (pix_clk_read !== 1'b1 && k < 4) begin @(negedge clk); k++; end
        check("abs_clk_high", {31'd0, pix_clk_read}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abs_busy",    {31'd0, busy},         0);
        check("abs_shutter", {31'd0, pix_shutter},  1);
        check("abs_valid",   {31'd0, out_valid},    0);
        check("abs_clkread", {31'd0, pix_clk_read}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) npulse[i] = 2;
        @(negedge clk);
        start_frame(16'd3);
        wait_idle("abs_re", 400);
        check_frame("abs_re", 15'h7FFC, 15'h7FFC, 15'h7FFC, 15'h7FFC, 130);

        // exp_len=0 gives a one-cycle window; a start while busy is ignored
        for (int i = 0; i < NP; i++) npulse[i] = 1;
        start_frame(16'd0);
        repeat (40) @(negedge clk);
        start_frame(16'd50);
        wait_idle("e0", 400);
        check("e0_low_cyc", low_cyc, 1);
        repeat (10) @(negedge clk);
        check("e0_stays_idle", {31'd0, busy}, 0);
        check_frame("e0", 15'h7FFE, 15'h7FFE, 15'h7FFE, 15'h7FFE, 128);

        // Synchronous reset mid-SHIFT
        start_frame(16'd4);
        k = 0;
        while (rises < 20 && k < 300) begin @(negedge clk); k++; end
        check("sr_reached_shift", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("sr_busy",    {31'd0, busy},         0);
        check("sr_shutter", {31'd0, pix_shutter},  1);
        check("sr_clkread", {31'd0, pix_clk_read}, 0);
        check("sr_pixrst",  {31'd0, pix_reset},    0);
        check("sr_serin",   {31'd0, pix_ser_in},   1);
        check("sr_valid",   {31'd0, out_valid},    0);
        check("sr_data",    {17'd0, out_data},     0);
        check("sr_pix",     {30'd0, out_pix},      0);
        reset = 1'b0;
        r0 = rises;
        repeat (20) @(negedge clk);
        check("sr_no_more_clk", rises, r0);
        check("sr_idle",        {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
